lcd_write_sequencer: RTL and testbench
======================================

# lcd_write_sequencer

Upstream feeder for the character-LCD Avalon slave. Accepts command and data bytes on a valid/ready stream, buffers them in a FIFO and turns each byte into a timed Avalon master cycle on that slave. After every write it polls the HD44780 busy flag, so the slave's strobe (E = read | write) meets the panel's setup, pulse-width and cycle-time limits with no software timing.

## Interface
- FIFO_DEPTH, 16: entries in the input FIFO; power of two, ≥2.
- SETUP_CYCLES, 2: cycles address and writedata are stable before read/write rises.
- E_PULSE_CYCLES, 12: cycles lcd_write/lcd_read stay high; 240 ns at 50 MHz.
- E_GAP_CYCLES, 14: low cycles after every strobe before the next SETUP.
- POLL_LIMIT, 4096: busy polls per byte before giving up.
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  byte offered.
- in_ready  out  1  FIFO not full.
- in_data  in  8  byte to send.
- in_is_cmd  in  1  1 = instruction register (RS=0), 0 = data register (RS=1).
- lcd_address  out  2  to slave address: 0 = write cmd, 1 = read status, 2 = write data.
- lcd_write  out  1  to slave write.
- lcd_read  out  1  to slave read.
- lcd_begintransfer  out  1  first cycle of each strobe.
- lcd_writedata  out  8  to slave writedata.
- lcd_readdata  in  8  from slave readdata; bit 7 = busy flag.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- timeout_err  out  1  sticky; set when POLL_LIMIT is reached.

## Operation
- FIFO stores {in_is_cmd, in_data} (9 bits) and is first-word-fall-through. Push on in_valid & in_ready. in_ready = !full. A push while full is impossible because in_ready is low.
- FSM states: IDLE, W_SETUP, W_STROBE, W_GAP, P_SETUP, P_STROBE, P_GAP. One down-counter times every state.
- IDLE: if the FIFO is non-empty, pop, latch the byte, go to W_SETUP.
- W_SETUP: lcd_address = 0 (cmd) or 2 (data), lcd_writedata = byte. Lasts SETUP_CYCLES.
- W_STROBE: lcd_write = 1 for E_PULSE_CYCLES. Address and data are held.
- W_GAP: strobe low for E_GAP_CYCLES, then P_SETUP.
- P_SETUP: lcd_address = 1, lcd_writedata = 0. Lasts SETUP_CYCLES.
- P_STROBE: lcd_read = 1 for E_PULSE_CYCLES. lcd_readdata[7] is sampled on the last strobe cycle.
- P_GAP: lasts E_GAP_CYCLES. Then:
  - sampled busy = 0: go to IDLE.
  - sampled busy = 1: increment the poll counter; if it equals POLL_LIMIT, set timeout_err and go to IDLE (byte dropped); otherwise go to P_SETUP.
- The poll counter clears on every pop.
- timeout_err clears only on reset.
- lcd_write and lcd_read are never high together, and a strobe is always preceded by SETUP and followed by GAP.

## Timing
- Reset values: lcd_write/lcd_read/lcd_begintransfer/lcd_address/lcd_writedata = 0, timeout_err = 0, busy = 0, in_ready = 1. FIFO is empty and the FSM is in IDLE.
- Byte accepted at edge T into an empty FIFO with the FSM in IDLE:
  - pop at edge T+1, enters W_SETUP;
  - lcd_write rises at edge T+1+SETUP_CYCLES and stays high exactly E_PULSE_CYCLES;
  - lcd_begintransfer is high for that first strobe cycle only.
- Minimum per-byte time (one poll, not busy): 2×(SETUP_CYCLES+E_PULSE_CYCLES+E_GAP_CYCLES)+1 cycles = 57 with defaults.
- A push and a pop in the same cycle leave the FIFO count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-strobe: all strobes are low after the next edge, and FIFO contents are discarded.

## Configuration
- LCD_SEQ_INIT_EN defined: after reset the FSM first sends the internal command list 0x38, 0x0C, 0x01, 0x06 through the same W_/P_ path, then serves the FIFO.
  - in_ready is still 1 during this phase, so bytes queue.
  - busy is 1 until the list completes.
- Not defined: the FSM starts in IDLE and only FIFO bytes are sent.

## Test plan
- Reset → all outputs at reset values. Push cmd 0x01 with the slave model returning busy = 0 → one lcd_write of 12 cycles at address 0 with writedata 0x01 starting 3 cycles after the push edge, then one lcd_read at address 1, then busy = 0.
- Push data 0x41 with the model holding busy = 1 for 3 polls → write at address 2 with writedata 0x41, then 4 read strobes, then IDLE; timeout_err = 0.
- Push 17 bytes back-to-back with the slave stalled by busy → in_ready low while the FIFO holds 16 entries (popped head in flight). All 17 bytes appear on lcd_writedata in order.
- Model busy stuck at 1 with POLL_LIMIT = 4 → 4 polls, timeout_err = 1, the next queued byte is still sent.
- Assert reset during W_STROBE → lcd_write = 0 on the next edge, busy = 0, a following push is sent normally.
- With LCD_SEQ_INIT_EN defined → the first four writes are 0x38, 0x0C, 0x01, 0x06 at address 0, then FIFO bytes.

Source files
------------

// File: rtl/lcd_write_sequencer.sv
// Byte FIFO feeding a timed HD44780 write/busy-poll sequencer for the LCD Avalon slave.
// Define LCD_SEQ_INIT_EN to send the panel init list (0x38,0x0C,0x01,0x06) after reset.
module lcd_write_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int SETUP_CYCLES   = 2,
  parameter int E_PULSE_CYCLES = 12,
  parameter int E_GAP_CYCLES   = 14,
  parameter int POLL_LIMIT     = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_cmd,
  output logic [1:0] lcd_address,
  output logic       lcd_write,
  output logic       lcd_read,
  output logic       lcd_begintransfer,
  output logic [7:0] lcd_writedata,
  input  logic [7:0] lcd_readdata,
  output logic       busy,
  output logic       timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SP_MAX = (SETUP_CYCLES > E_PULSE_CYCLES) ?
                          SETUP_CYCLES : E_PULSE_CYCLES;
  localparam int CNT_MAX = (SP_MAX > E_GAP_CYCLES) ? SP_MAX : E_GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(E_GAP_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_GAP,
    P_SETUP,
    P_STROBE,
    P_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] poll_q;
  logic          smp_busy_q;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic       take;
  logic       init_active;
  logic [8:0] src;
  logic       cnt_done;
  logic       unused_rd;

  assign unused_rd = ^lcd_readdata[6:0];

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign in_ready = !full;
  assign push     = in_valid & in_ready;
  assign cnt_done = (cnt_q == '0);

`ifdef LCD_SEQ_INIT_EN
  logic [2:0] init_idx_q;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    unique case (idx)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h0C;
      2'd2:    c = 8'h01;
      default: c = 8'h06;
    endcase
    return c;
  endfunction

  assign init_active = (init_idx_q != 3'd4);
  assign src = init_active ? {1'b1, init_cmd(init_idx_q[1:0])}
                           : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      init_idx_q <= '0;
    end else if (state_q == IDLE && init_active) begin
      init_idx_q <= init_idx_q + 3'd1;
    end
  end
`else
  assign init_active = 1'b0;
  assign src         = mem_q[rd_ptr_q];
`endif

  assign take = (state_q == IDLE) && (init_active || !empty);
  assign pop  = take && !init_active;
  assign busy = !empty || (state_q != IDLE) || init_active;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_is_cmd, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      poll_q            <= '0;
      smp_busy_q        <= 1'b0;
      lcd_address       <= 2'd0;
      lcd_writedata     <= 8'h00;
      lcd_write         <= 1'b0;
      lcd_read          <= 1'b0;
      lcd_begintransfer <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      lcd_begintransfer <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (take) begin
            poll_q        <= '0;
            lcd_address   <= src[8] ? 2'd0 : 2'd2;
            lcd_writedata <= src[7:0];
            cnt_q         <= SETUP_LD;
            state_q       <= W_SETUP;
          end
        end
        W_SETUP: begin
          if (cnt_done) begin
            lcd_write         <= 1'b1;
            lcd_begintransfer <= 1'b1;
            cnt_q             <= PULSE_LD;
            state_q           <= W_STROBE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        W_STROBE: begin
          if (cnt_done) begin
            lcd_write <= 1'b0;
            cnt_q     <= GAP_LD;
            state_q   <= W_GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        W_GAP: begin
          if (cnt_done) begin
            lcd_address   <= 2'd1;
            lcd_writedata <= 8'h00;
            cnt_q         <= SETUP_LD;
            state_q       <= P_SETUP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        P_SETUP: begin
          if (cnt_done) begin
            lcd_read          <= 1'b1;
            lcd_begintransfer <= 1'b1;
            cnt_q             <= PULSE_LD;
            state_q           <= P_STROBE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        P_STROBE: begin
          // Busy flag is taken on the last cycle E is high.
          if (cnt_done) begin
            lcd_read   <= 1'b0;
            smp_busy_q <= lcd_readdata[7];
            cnt_q      <= GAP_LD;
            state_q    <= P_GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        P_GAP: begin
          if (cnt_done) begin
            if (!smp_busy_q) begin
              state_q <= IDLE;
            end else if (poll_q == POLL_LAST) begin
              timeout_err <= 1'b1;
              state_q     <= IDLE;
            end else begin
              poll_q  <= poll_q + PW'(1);
              cnt_q   <= SETUP_LD;
              state_q <= P_SETUP;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_strobe_excl: assert property (
    @(posedge clk) disable iff (reset) !(lcd_write && lcd_read));

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer: slave model drives busy polls,
// monitor checks every strobe against the queued expectation.
module tb_lcd_write_sequencer;

  localparam int PL    = 4;
  localparam int SETUP = 2;
  localparam int PULSE = 12;
  localparam int GAP   = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_is_cmd = 1'b0;
  logic [1:0] lcd_address;
  logic       lcd_write;
  logic       lcd_read;
  logic       lcd_begintransfer;
  logic [7:0] lcd_writedata;
  logic [7:0] lcd_readdata = 8'h00;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  lcd_write_sequencer #(
    .FIFO_DEPTH    (16),
    .SETUP_CYCLES  (SETUP),
    .E_PULSE_CYCLES(PULSE),
    .E_GAP_CYCLES  (GAP),
    .POLL_LIMIT    (PL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_is_cmd        (in_is_cmd),
    .lcd_address      (lcd_address),
    .lcd_write        (lcd_write),
    .lcd_read         (lcd_read),
    .lcd_begintransfer(lcd_begintransfer),
    .lcd_writedata    (lcd_writedata),
    .lcd_readdata     (lcd_readdata),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  typedef struct {
    logic       cmd;
    logic [7:0] data;
    int         nb;
  } item_t;

  item_t sb[$];
  item_t cur;
  bit    cur_valid = 0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wlen = 0, rlen = 0, reads = 0, busy_cnt = 0;
  int last_fall = -1000, wr_rise = 0, prev_wr_rise = 0, push_edge = 0;
  bit pw = 0, pr = 0, to_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Expected polls: one per busy answer plus the final ready one,
  // capped by the poll limit, which also raises the sticky error.
  task automatic finalize();
    int er;
    er = (cur.nb >= PL) ? PL : cur.nb + 1;
    chk("poll_count", reads, er);
    if (cur.nb >= PL) to_exp = 1;
    chk("timeout_err", timeout_err, to_exp);
    cur_valid = 0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      cur_valid = 0;
      busy_cnt = 0;
      to_exp = 0;
      wlen = 0;
      rlen = 0;
      last_fall = -1000;
`ifdef LCD_SEQ_INIT_EN
      sb.push_back('{1'b1, 8'h38, 0});
      sb.push_back('{1'b1, 8'h0C, 0});
      sb.push_back('{1'b1, 8'h01, 0});
      sb.push_back('{1'b1, 8'h06, 0});
`endif
    end else begin
      if (lcd_write && !pw) begin
        chk("wr_begin", lcd_begintransfer, 1);
        chk("wr_excl", lcd_read, 0);
        chk("wr_spacing", (cyc - last_fall) >= (GAP + SETUP), 1);
        if (cur_valid) finalize();
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: data 0x%0h with empty queue",
                   lcd_writedata);
        end else begin
          cur = sb.pop_front();
          cur_valid = 1;
          chk("wr_addr", lcd_address, cur.cmd ? 0 : 2);
          chk("wr_data", lcd_writedata, cur.data);
          busy_cnt = cur.nb;
          reads = 0;
          prev_wr_rise = wr_rise;
          wr_rise = cyc;
        end
        wlen = 1;
      end else if (lcd_write) begin
        wlen++;
        if (wlen == 2) chk("wr_begin_once", lcd_begintransfer, 0);
      end
      if (!lcd_write && pw) begin
        chk("wr_width", wlen, PULSE);
        last_fall = cyc;
      end
      if (lcd_read && !pr) begin
        chk("rd_begin", lcd_begintransfer, 1);
        chk("rd_spacing", (cyc - last_fall) >= (GAP + SETUP), 1);
        chk("rd_addr", lcd_address, 1);
        chk("rd_wdata", lcd_writedata, 0);
        chk("rd_owner", cur_valid, 1);
        reads++;
        rlen = 1;
      end else if (lcd_read) begin
        rlen++;
      end
      if (!lcd_read && pr) begin
        chk("rd_width", rlen, PULSE);
        last_fall = cyc;
        if (busy_cnt > 0) busy_cnt--;
      end
    end
    lcd_readdata = {busy_cnt > 0, 7'($urandom)};
    pw = lcd_write;
    pr = lcd_read;
  end

  task automatic push(input bit cmd, input logic [7:0] data, input int nb);
    int g = 0;
    in_valid = 1;
    in_is_cmd = cmd;
    in_data = data;
    while (!in_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: in_ready still 0 after %0d cycles", g);
    end
    push_edge = cyc + 1;
    sb.push_back('{cmd, data, nb});
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_idle", busy, 0);
    chk("drain_queue", sb.size(), 0);
    if (cur_valid) finalize();
  endtask

  function automatic int rand_nb();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 0;
    if (r < 8) return r - 4;
    return PL + 1;
  endfunction

  initial begin
    int g;
    int t0;
    repeat (3) @(negedge clk);
    chk("rst_write", lcd_write, 0);
    chk("rst_read", lcd_read, 0);
    chk("rst_begin", lcd_begintransfer, 0);
    chk("rst_addr", lcd_address, 0);
    chk("rst_wdata", lcd_writedata, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_ready", in_ready, 1);
`ifndef LCD_SEQ_INIT_EN
    chk("rst_busy", busy, 0);
`endif
    reset = 0;
    @(negedge clk);

    push(1, 8'h01, 0);
    t0 = push_edge;
    chk("busy_after_push", busy, 1);
    drain();
`ifndef LCD_SEQ_INIT_EN
    chk("wr_latency", wr_rise - t0, SETUP + 1);
`endif

    push(1, 8'h80, 0);
    push(0, 8'h5A, 0);
    drain();
    chk("byte_period", wr_rise - prev_wr_rise,
        2 * (SETUP + PULSE + GAP) + 1);

    push(0, 8'h41, 3);
    drain();
    chk("no_timeout", timeout_err, 0);

    push(1, 8'hC0, 3);
    for (int i = 0; i < 16; i++) begin
      push($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
    end
    chk("fifo_full_ready", in_ready, 0);
    chk("fifo_full_busy", busy, 1);
    drain();

    push(1, 8'h33, 1000);
    push(0, 8'h44, 0);
    drain();
    chk("timeout_sticky", timeout_err, 1);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      push($urandom_range(0, 1), 8'($urandom), rand_nb());
    end
    drain();

    push(0, 8'h77, 0);
    g = 0;
    while (!lcd_write && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("strobe_seen", lcd_write, 1);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_write", lcd_write, 0);
    chk("midrst_read", lcd_read, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_timeout", timeout_err, 0);
`ifndef LCD_SEQ_INIT_EN
    chk("midrst_busy", busy, 0);
`endif
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    push(1, 8'h0F, 1);
    t0 = push_edge;
    drain();
`ifndef LCD_SEQ_INIT_EN
    chk("post_rst_latency", wr_rise - t0, SETUP + 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
